// File: rtl/wave_capture_pkg.sv
// Shared encodings for the waveform trigger-and-capture front end.
package wave_capture_pkg;

  typedef enum logic [1:0] {
    ST_ARMED     = 2'b00,
    ST_ACTIVE    = 2'b01,
    ST_WAIT_READ = 2'b10
  } cap_state_e;

  localparam logic [1:0] TRIG_RISE = 2'd0;
  localparam logic [1:0] TRIG_FALL = 2'd1;
  localparam logic [1:0] TRIG_FREE = 2'd2;
  localparam logic [1:0] TRIG_AUTO = 2'd3;

endpackage

// File: rtl/wave_trigger_detect.sv
// Level-crossing trigger detector: previous-sample history, crossing
// comparators and the auto-mode timeout counter.
module wave_trigger_detect
  import wave_capture_pkg::*;
#(
  parameter int SAMPLE_W     = 16,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       armed,
  input  logic                       sample_vld,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic        [1:0]          trig_mode,
  input  logic signed [SAMPLE_W-1:0] trig_level,
  output logic                       trig,
  output logic                       forced
);

  localparam int CNT_W = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(AUTO_TIMEOUT - 1);

  logic signed [SAMPLE_W-1:0] prev_q;
  logic                       prev_valid_q;
  logic        [CNT_W-1:0]    cnt_q;
  logic                       rise, fall, timeout;

  always_ff @(posedge clk) begin
    if (sample_vld) prev_q <= sample;
  end

  // Clear wins over a same-cycle sample so the first sample after arming
  // only primes the history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      if (clear)           prev_valid_q <= 1'b0;
      else if (sample_vld) prev_valid_q <= 1'b1;

      if (clear || (armed && trig_mode != TRIG_AUTO))
        cnt_q <= '0;
      else if (armed && sample_vld && !trig)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign rise    = prev_valid_q && (prev_q <  trig_level) && (sample >= trig_level);
  assign fall    = prev_valid_q && (prev_q >= trig_level) && (sample <  trig_level);
  assign timeout = (cnt_q == TIMEOUT_LAST);

  always_comb begin
    trig   = 1'b0;
    forced = 1'b0;
    if (armed && sample_vld) begin
      unique case (trig_mode)
        TRIG_RISE: trig = rise;
        TRIG_FALL: trig = fall;
        TRIG_FREE: trig = 1'b1;
        default: begin
          if (rise) begin
            trig = 1'b1;
          end else if (timeout) begin
            trig   = 1'b1;
            forced = 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/wave_capture_trig.sv
// Trigger-and-capture front end: writes one decimated offset-binary frame
// into the idle half of a ping-pong RAM, then hands it to the display.
module wave_capture_trig
  import wave_capture_pkg::*;
#(
  parameter int SAMPLE_W     = 16,
  parameter int OUT_W        = 8,
  parameter int ADDR_W       = 8,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       new_sample_ready,
  input  logic signed [SAMPLE_W-1:0] new_sample_in,
  input  logic        [1:0]          trig_mode,
  input  logic signed [SAMPLE_W-1:0] trig_level,
  input  logic        [3:0]          decim,
  input  logic                       wave_display_idle,
  output logic        [ADDR_W:0]     write_address,
  output logic                       write_enable,
  output logic        [OUT_W-1:0]    write_sample,
  output logic                       read_index,
  output logic                       trig_forced
);

  localparam logic [ADDR_W-1:0] IDX_LAST = '1;
  localparam logic [OUT_W-1:0]  MSB_FLIP = {1'b1, {(OUT_W-1){1'b0}}};

  function automatic logic [OUT_W-1:0] to_offset_bin(input logic signed [SAMPLE_W-1:0] s);
    return s[SAMPLE_W-1 -: OUT_W] ^ MSB_FLIP;
  endfunction

  cap_state_e         state_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [3:0]         dcnt_q;
  logic [3:0]         decim_q;
  logic               frame_forced_q;
  logic               we_q;
  logic [ADDR_W:0]    waddr_q;
  logic [OUT_W-1:0]   wsample_q;
  logic               rd_idx_q;
  logic               trig_forced_q;

  logic armed, arm_entry, trig, forced;
  logic [3:0] dcnt_d;

  assign armed     = (state_q == ST_ARMED);
  assign arm_entry = (state_q == ST_WAIT_READ) && wave_display_idle;
  assign dcnt_d    = (dcnt_q == decim_q) ? 4'd0 : dcnt_q + 4'd1;

  wave_trigger_detect #(
    .SAMPLE_W     (SAMPLE_W),
    .AUTO_TIMEOUT (AUTO_TIMEOUT)
  ) u_trig (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (arm_entry),
    .armed      (armed),
    .sample_vld (new_sample_ready),
    .sample     (new_sample_in),
    .trig_mode  (trig_mode),
    .trig_level (trig_level),
    .trig       (trig),
    .forced     (forced)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_ARMED;
      idx_q          <= '0;
      dcnt_q         <= '0;
      decim_q        <= '0;
      frame_forced_q <= 1'b0;
      we_q           <= 1'b0;
      waddr_q        <= '0;
      wsample_q      <= '0;
      rd_idx_q       <= 1'b0;
      trig_forced_q  <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        ST_ARMED: begin
          // The triggering sample itself is frame index 0 and decimation phase 0.
          if (trig) begin
            we_q           <= 1'b1;
            waddr_q        <= {~rd_idx_q, {ADDR_W{1'b0}}};
            wsample_q      <= to_offset_bin(new_sample_in);
            decim_q        <= decim;
            dcnt_q         <= (decim == 4'd0) ? 4'd0 : 4'd1;
            idx_q          <= ADDR_W'(1);
            frame_forced_q <= forced;
            state_q        <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (new_sample_ready) begin
            dcnt_q <= dcnt_d;
            if (dcnt_q == 4'd0) begin
              we_q      <= 1'b1;
              waddr_q   <= {~rd_idx_q, idx_q};
              wsample_q <= to_offset_bin(new_sample_in);
              idx_q     <= idx_q + 1'b1;
              if (idx_q == IDX_LAST) begin
                state_q       <= ST_WAIT_READ;
                trig_forced_q <= frame_forced_q;
              end
            end
          end
        end
        ST_WAIT_READ: begin
          if (wave_display_idle) begin
            rd_idx_q <= ~rd_idx_q;
            state_q  <= ST_ARMED;
          end
        end
        default: state_q <= ST_ARMED;
      endcase
    end
  end

  assign write_enable  = we_q;
  assign write_address = waddr_q;
  assign write_sample  = wsample_q;
  assign read_index    = rd_idx_q;
  assign trig_forced   = trig_forced_q;

endmodule

// File: tb/tb_wave_capture_trig.sv
// Randomised bench for wave_capture_trig against a frame-level behavioural model.
module tb_wave_capture_trig;

  localparam int SW = 16, OW = 8, AW = 8, TO = 16, DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_n;
  logic                 rdy;
  logic signed [SW-1:0] smp;
  logic [1:0]           mode;
  logic signed [SW-1:0] lvl;
  logic [3:0]           dec;
  logic                 idle;
  logic [AW:0]          waddr;
  logic                 we;
  logic [OW-1:0]        wsmp;
  logic                 ridx;
  logic                 tforced;

  int n_tests = 0, n_fail = 0;

  wave_capture_trig #(
    .SAMPLE_W (SW), .OUT_W (OW), .ADDR_W (AW), .AUTO_TIMEOUT (TO)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .new_sample_ready  (rdy),
    .new_sample_in     (smp),
    .trig_mode         (mode),
    .trig_level        (lvl),
    .decim             (dec),
    .wave_display_idle (idle),
    .write_address     (waddr),
    .write_enable      (we),
    .write_sample      (wsmp),
    .read_index        (ridx),
    .trig_forced       (tforced)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: phase 0 = waiting for trigger, 1 = capturing, 2 = awaiting display.
  int m_phase, m_prev, m_cnt, m_idx, m_since, m_dec;
  bit m_prev_ok, m_frame_forced, m_forced, m_ridx;
  bit e_we;
  int e_addr, e_data;
  int dut_writes, f_addr, f_data;

  function automatic int ob(input int s);
    return ((s >>> (SW - OW)) + (1 << (OW - 1))) & ((1 << OW) - 1);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_prev = 0; m_cnt = 0; m_idx = 0; m_since = 0; m_dec = 0;
    m_prev_ok = 0; m_frame_forced = 0; m_forced = 0; m_ridx = 0;
  endtask

  task automatic model_step();
    int cur, level;
    bit rise, fall, t, f;
    cur = int'(smp);
    level = int'(lvl);
    e_we = 0;
    if (m_phase == 0) begin
      if (rdy) begin
        rise = m_prev_ok && (m_prev < level) && (cur >= level);
        fall = m_prev_ok && (m_prev >= level) && (cur < level);
        t = 0; f = 0;
        case (int'(mode))
          0: t = rise;
          1: t = fall;
          2: t = 1;
          default: begin
            if (rise) t = 1;
            else if (m_cnt + 1 == TO) begin t = 1; f = 1; end
          end
        endcase
        if (int'(mode) == 3) m_cnt++; else m_cnt = 0;
        if (t) begin
          e_we = 1; e_addr = (m_ridx ? 0 : DEPTH); e_data = ob(cur);
          m_phase = 1; m_idx = 1; m_since = 1; m_dec = int'(dec); m_frame_forced = f;
        end
        m_prev = cur; m_prev_ok = 1;
      end
    end else if (m_phase == 1) begin
      if (rdy) begin
        if (m_since % (m_dec + 1) == 0) begin
          e_we = 1; e_addr = (m_ridx ? 0 : DEPTH) + m_idx; e_data = ob(cur);
          m_idx++;
          if (m_idx == DEPTH) begin m_phase = 2; m_forced = m_frame_forced; end
        end
        m_since++;
        m_prev = cur; m_prev_ok = 1;
      end
    end else begin
      if (rdy) begin m_prev = cur; m_prev_ok = 1; end
      if (idle) begin m_ridx = !m_ridx; m_phase = 0; m_prev_ok = 0; m_cnt = 0; end
    end
  endtask

  // Inputs are applied just after an edge and held until the next one.
  task automatic step(input bit r, input int s, input bit id);
    rdy = r; smp = s[SW-1:0]; idle = id;
    @(posedge clk);
    model_step();
    #1;
    check_eq("write_enable", 32'(we), 32'(e_we));
    if (e_we) begin
      check_eq("write_address", 32'(waddr), e_addr);
      check_eq("write_sample", 32'(wsmp), e_data);
    end
    if (we) begin
      if (dut_writes == 0) begin f_addr = int'(waddr); f_data = int'(wsmp); end
      dut_writes++;
    end
    check_eq("read_index", 32'(ridx), 32'(m_ridx));
    check_eq("trig_forced", 32'(tforced), 32'(m_forced));
  endtask

  task automatic run_frame(input int lo, input int span);
    for (int i = 0; i < 4000 && m_phase != 2; i++)
      step($urandom_range(3) != 0, lo + int'($urandom_range(span)), 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; rdy = 1'b0; smp = '0; mode = 2'd0; lvl = '0; dec = 4'd0; idle = 1'b0;
    dut_writes = 0; f_addr = 0; f_data = 0; e_we = 0; e_addr = 0; e_data = 0;
    model_reset();
    #12;
    check_eq("rst_we", 32'(we), 0);
    check_eq("rst_addr", 32'(waddr), 0);
    check_eq("rst_sample", 32'(wsmp), 0);
    check_eq("rst_ridx", 32'(ridx), 0);
    check_eq("rst_forced", 32'(tforced), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Rising ramp, back-to-back strobes
    mode = 2'd0; lvl = '0; dec = 4'd0; dut_writes = 0;
    for (int k = 0; k < 300; k++) step(1'b1, -4 + 2 * k, 1'b0);
    check_eq("rise_first_addr", f_addr, 32'h100);
    check_eq("rise_first_data", f_data, 32'h80);
    check_eq("rise_nwrites", dut_writes, DEPTH);

    // Display busy: no writes, read_index holds
    for (int k = 0; k < 100; k++) step($urandom_range(1) == 1, int'($urandom_range(4000)) - 2000, 1'b0);
    check_eq("hold_nwrites", dut_writes, DEPTH);
    check_eq("hold_ridx", 32'(ridx), 0);
    step(1'b0, 0, 1'b1);
    check_eq("handover_ridx", 32'(ridx), 1);
    dut_writes = 0;
    for (int k = 0; k < 300; k++) step(1'b1, -4 + 2 * k, 1'b0);
    check_eq("second_half_addr", f_addr, 32'h000);
    check_eq("second_nwrites", dut_writes, DEPTH);
    step(1'b0, 0, 1'b1);

    // Falling trigger ignores the rising crossing
    mode = 2'd1; lvl = 16'sh1000; dut_writes = 0;
    step(1'b1, 'h0000, 1'b0);
    step(1'b1, 'h2000, 1'b0);
    check_eq("fall_no_rise_trig", dut_writes, 0);
    step(1'b1, 'h0800, 1'b0);
    check_eq("fall_first_data", f_data, 32'h88);
    check_eq("fall_first_addr", f_addr, 32'h100);
    run_frame(-30000, 60000);
    check_eq("fall_nwrites", dut_writes, DEPTH);
    step(1'b0, 0, 1'b1);

    // Free-run with decimation by 4
    mode = 2'd2; dec = 4'd3; dut_writes = 0;
    for (int k = 0; k < 1024; k++) begin
      step(1'b1, int'($urandom_range(60000)) - 30000, 1'b0);
      if (we) check_eq("dec_strobe_phase", k % 4, 0);
    end
    check_eq("dec_nwrites", dut_writes, DEPTH);
    step(1'b0, 0, 1'b1);

    // Auto timeout on a flat input, then a real crossing clears the flag
    mode = 2'd3; lvl = 16'sd100; dec = 4'd0; dut_writes = 0;
    for (int k = 0; k < TO - 1; k++) step(1'b1, 5, 1'b0);
    check_eq("auto_pre_timeout", dut_writes, 0);
    step(1'b1, 5, 1'b0);
    check_eq("auto_forced_trig", dut_writes, 1);
    run_frame(5, 0);
    check_eq("auto_nwrites", dut_writes, DEPTH);
    check_eq("auto_forced_flag", 32'(tforced), 1);
    step(1'b0, 0, 1'b1);
    dut_writes = 0;
    step(1'b1, 5, 1'b0);
    step(1'b1, 200, 1'b0);
    check_eq("auto_real_trig", dut_writes, 1);
    run_frame(-500, 1000);
    check_eq("auto_real_flag", 32'(tforced), 0);
    step(1'b0, 0, 1'b1);

    // Asynchronous reset mid-frame
    mode = 2'd0; lvl = '0; dut_writes = 0;
    step(1'b1, -1, 1'b0);
    step(1'b1, 1, 1'b0);
    for (int i = 0; i < 200 && m_idx < 38; i++) step(1'b1, int'($urandom_range(2000)) - 1000, 1'b0);
    check_eq("midrst_progress", dut_writes, 38);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("midrst_we", 32'(we), 0);
    check_eq("midrst_addr", 32'(waddr), 0);
    check_eq("midrst_sample", 32'(wsmp), 0);
    check_eq("midrst_ridx", 32'(ridx), 0);
    check_eq("midrst_forced", 32'(tforced), 0);
    #2 reset_n = 1'b1;
    dut_writes = 0;
    step(1'b1, 1, 1'b0);
    step(1'b1, -1, 1'b0);
    check_eq("midrst_no_early_trig", dut_writes, 0);
    step(1'b1, 1, 1'b0);
    check_eq("midrst_retrig", dut_writes, 1);
    check_eq("midrst_retrig_addr", f_addr, 32'h100);

    // Random traffic: mode changes only take effect while armed
    for (int i = 0; i < 8000; i++) begin
      if (m_phase != 0) mode = 2'($urandom_range(3));
      lvl = SW'(int'($urandom_range(100)) - 50);
      dec = 4'($urandom_range(2));
      step($urandom_range(9) < 7, int'($urandom_range(200)) - 100, $urandom_range(9) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_capture_trig.md
# wave_capture_trig

Parametrised trigger-and-capture front end for the waveform display path. It watches the audio sample stream and triggers on a configurable level crossing (rising, falling, free-run or auto with timeout). After a trigger it writes one decimated, offset-binary frame into the inactive half of the ping-pong display RAM. It then hands that half to the display by toggling `read_index` once the display reports idle.

## Interface
Parameters:
- `SAMPLE_W`, 16: width of the incoming signed two's-complement sample.
- `OUT_W`, 8: width of the stored display sample; must be ≤ `SAMPLE_W`.
- `ADDR_W`, 8: frame depth is 2^`ADDR_W` samples per RAM half.
- `AUTO_TIMEOUT`, 4096: number of accepted samples spent in ARMED in auto mode before a forced trigger.

Ports:
- `clk`  in  1  system clock; the block has one clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `new_sample_ready`  in  1  one-cycle strobe; `new_sample_in` is valid in the same cycle.
- `new_sample_in`  in  `SAMPLE_W`  signed sample.
- `trig_mode`  in  2  trigger mode: 0 = rising, 1 = falling, 2 = free-run, 3 = auto (rising with timeout).
- `trig_level`  in  `SAMPLE_W`  signed trigger threshold.
- `decim`  in  4  keep one sample in every `decim`+1 samples.
- `wave_display_idle`  in  1  display is not reading the RAM.
- `write_address`  out  `ADDR_W`+1  {~`read_index`, frame index}.
- `write_enable`  out  1  one-cycle RAM write strobe.
- `write_sample`  out  `OUT_W`  offset-binary sample.
- `read_index`  out  1  RAM half currently owned by the display.
- `trig_forced`  out  1  high if the most recently completed frame was an auto-forced trigger.

## Operation
State machine: ARMED → ACTIVE → WAIT_READ → ARMED.

- **Previous-sample register.**
  - Updated on every `new_sample_ready`, in all states.
  - The `prev_valid` flag is cleared by reset and by entry to ARMED, and is set by the first sample after that.
  - No trigger can occur while `prev_valid` is 0.
- **Crossing rules.** Comparisons are signed, at full `SAMPLE_W`.
  - Rising: prev < `trig_level` and cur ≥ `trig_level`.
  - Falling: prev ≥ `trig_level` and cur < `trig_level`.
- **ARMED.**
  - `trig_mode`, `trig_level` and `decim` are evaluated live; `decim` is latched at the trigger.
  - Free-run triggers on the first accepted sample, regardless of `prev_valid`.
  - Auto mode counts accepted samples. It forces a trigger on sample number `AUTO_TIMEOUT` if no crossing has occurred, and sets the forced flag for that frame.
  - The triggering sample is frame index 0 and is written.
- **ACTIVE.**
  - A decimation counter is reset to 0 at the trigger. A sample is written when the counter is 0; the counter wraps at the latched `decim`.
  - The frame index increments after each write.
  - After index 2^`ADDR_W`−1 is written, the block goes to WAIT_READ.
  - `trig_forced` updates on this transition.
- **WAIT_READ.**
  - No writes occur.
  - In the first cycle that `wave_display_idle` is 1, `read_index` toggles and the state goes to ARMED.
- **Sample conversion.** `write_sample` = `new_sample_in`[`SAMPLE_W`−1 : `SAMPLE_W`−`OUT_W`] with its MSB inverted. No rounding.
- **Mode changes.** A change to `trig_mode` during ACTIVE or WAIT_READ has no effect until the next ARMED.

## Timing
- **Reset values.** State ARMED; `read_index`=0; `write_enable`=0; `write_address`=0; `write_sample`=0; `trig_forced`=0; all counters 0; `prev_valid`=0.
- **Output registration.** All outputs are registered. `write_enable`, `write_address` and `write_sample` appear in the cycle after the accepting `new_sample_ready`.
- **Write-enable width.** `write_enable` is high for exactly one cycle per write. At most one write occurs per strobe.
- **Trigger latency.**
  - The trigger sample's write occurs one cycle after its strobe.
  - State is ACTIVE on that same edge.
  - The last write and the entry to WAIT_READ occur on the same edge.
- **Back-to-back strobes.** Strobes on consecutive cycles must be handled with no sample loss.
- **Idle timing.**
  - If `wave_display_idle` is already high when WAIT_READ is entered, the block leaves WAIT_READ one cycle later.
  - A `new_sample_ready` in that leaving cycle updates prev only; it cannot trigger, because `prev_valid` is cleared.
- **Mid-operation reset.** Asserting `reset_n` low at any time immediately forces all reset values, including during a write. Partial frames are discarded.

## Structure
- **Package `wave_capture_pkg`.**
  - State encoding: ARMED=2'b00, ACTIVE=2'b01, WAIT_READ=2'b10.
  - Trigger-mode constants: TRIG_RISE, TRIG_FALL, TRIG_FREE, TRIG_AUTO.
- **Sub-module `wave_trigger_detect`.**
  - Contains the previous-sample register, `prev_valid`, the crossing comparators and the auto-timeout counter.
  - Outputs a one-cycle `trig` and a `forced` flag.
  - Its clear input is driven on ARMED entry.
- **Top level.** The FSM, the frame and decimation counters, and the output registers.

## Test plan
- **Rising trigger.** Rising mode, `trig_level`=0, `decim`=0. Drive a ramp −4, −2, 0, 2, … → the first write is at address 0x100 with `write_sample`=0x80 (the sample 0). It is followed by 255 consecutive writes, then `read_index`=1 once idle.
- **Falling trigger.** Falling mode, `trig_level`=0x1000. Drive 0x2000 then 0x0800 → the write of 0x0800 maps to 0x88 at index 0. Rising crossings are ignored.
- **Decimation.** `decim`=3, free-run → exactly 256 writes over 1024 strobes. Writes are on strobes 0, 4, 8, …
- **Auto timeout.** Auto mode with a constant input of 5 and `AUTO_TIMEOUT`=16 → a forced trigger on the 16th ARMED sample. `trig_forced`=1 after the frame completes. A following real crossing clears it on the next frame.
- **Handover.** `wave_display_idle` is held low for 100 cycles in WAIT_READ → no writes and `read_index` is stable. When idle rises, `read_index` toggles once. The next frame writes the opposite half.
- **Reset mid-capture.** Pull `reset_n` low at frame index 37 → all outputs return to reset values asynchronously. After release, the block waits for a new valid crossing, needing two samples.
